// File: rtl/cpu_divmod_ctrl.sv
// cpu_divmod_ctrl
//   Sequences the shared multi-cycle divmod unit for the CPU exec stage.
//   One command at a time over req valid/ready; drives the divider through its
//   can_accept/data_ready protocol; resolves divide-by-zero and signed overflow
//   locally; bounds the divider wait with a timeout; returns quot/rem + tag.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    CPU command (valid/ready, sgn, num, denom, tag)
//   resp_*                   response (valid/ready, quot, rem, tag, flags)
//   div_enable/unsgn_or_sgn  command strobe and signedness to the divider
//   div_num/div_denom        operands to the divider
//   div_can_accept           divider idle
//   div_data_ready/quot/rem  divider result strobe and data
module cpu_divmod_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sgn,
  input  logic [WIDTH-1:0] req_num,
  input  logic [WIDTH-1:0] req_denom,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_quot,
  output logic [WIDTH-1:0] resp_rem,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_div_zero,
  output logic             resp_timeout,
  output logic             div_enable,
  output logic             div_unsgn_or_sgn,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_denom,
  input  logic             div_can_accept,
  input  logic             div_data_ready,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_denom;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic             r_to;

  logic w_denom_zero;
  logic w_ovf;
  logic w_cnt_last;

  assign w_denom_zero = (req_denom == '0);
  assign w_ovf        = req_sgn && (req_num == INT_MIN) && (req_denom == '1);
  assign w_cnt_last   = (r_cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_num   <= '0;
      r_denom <= '0;
      r_tag   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sgn   <= req_sgn;
            r_num   <= req_num;
            r_denom <= req_denom;
            r_tag   <= req_tag;
            // Zero divisor takes priority over the INT_MIN/-1 overflow case.
            if (w_denom_zero) begin
              r_quot  <= '1;
              r_rem   <= req_num;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_quot  <= req_num;
              r_rem   <= '0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (div_can_accept) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // Data arriving on the final allowed cycle beats the timeout.
          if (div_data_ready) begin
            r_quot  <= div_quot;
            r_rem   <= div_rem;
            r_to    <= 1'b0;
            r_state <= S_DONE;
          end else if (w_cnt_last) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_to    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_dz    <= 1'b0;
            r_to    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign resp_valid       = (r_state == S_DONE);
  assign div_enable       = (r_state == S_ISSUE);
  assign div_unsgn_or_sgn = r_sgn;
  assign div_num          = r_num;
  assign div_denom        = r_denom;
  assign resp_quot        = r_quot;
  assign resp_rem         = r_rem;
  assign resp_tag         = r_tag;
  assign resp_div_zero    = r_dz;
  assign resp_timeout     = r_to;

endmodule
